itf_dma_sched: RTL and testbench
================================

// Module: itf_dma_sched
// PURPOSE
//  Chip-side scheduler for the shared off-chip data port (Dat/DatVld/DatRdy + CmdVld/DatOE).
//  Arbitrates NUM_CH on-chip DMA channels round-robin and issues one command word per transfer.
//  Then moves LEN beats DRAM->chip (read) or chip->DRAM (write) and signals per-channel completion.
//  Sits between the pad/IO layer and the on-chip buffers. Yields the port to host ISA streaming (I_ISAVld).
// PARAMETERS
//  NUM_CH          4    number of DMA requesters
//  PORT_WIDTH      128  data port width (bits)
//  DRAM_ADDR_WIDTH 32   DRAM beat address width
//  LEN_WIDTH       16   transfer length field, in beats
// PORTS
//  clk          in   1                     system clock
//  rst_n        in   1                     async active-low reset
//  I_ISAVld     in   1                     host streaming ISA; port owned by host
//  ChReq        in   NUM_CH                transfer request, level, per channel
//  ChWr         in   NUM_CH                1=chip->DRAM (write), 0=DRAM->chip (read)
//  ChAddr       in   NUM_CH*DRAM_ADDR_WIDTH  DRAM start address, per channel
//  ChLen        in   NUM_CH*LEN_WIDTH      beats to move, per channel
//  ChGnt        out  NUM_CH                one-hot grant, held for the whole transfer
//  ChDone       out  NUM_CH                1-cycle completion pulse
//  ChWrDat      in   NUM_CH*PORT_WIDTH     write data, per channel
//  ChWrVld      in   NUM_CH                write data valid
//  ChWrRdy      out  NUM_CH                write data ready (granted channel only)
//  RdDat        out  PORT_WIDTH            read data, broadcast
//  RdVld        out  NUM_CH                read data valid (granted channel only)
//  RdRdy        in   NUM_CH                read data ready
//  O_CmdVld     out  1                     command word on the port
//  O_DatOE      out  1                     chip drives Dat/DatVld; host drives DatRdy
//  PadDatOut    out  PORT_WIDTH            port data driven by chip
//  PadDatVldOut out  1                     port valid driven by chip
//  PadDatRdyIn  in   1                     host ready, used while O_DatOE=1
//  PadDatIn     in   PORT_WIDTH            port data driven by host
//  PadDatVldIn  in   1                     host valid, used while O_DatOE=0
//  PadDatRdyOut out  1                     chip ready to host, used while O_DatOE=0
// BEHAVIOUR
//  Reset: every output is 0. state=IDLE, RR pointer=0, beat count=0. Reset mid-transfer aborts with no ChDone.
//  FSM IDLE->CMD->(RD|WR)->DONE->IDLE. Registered state. Outputs decoded from state and latched idx.
//  IDLE: if !I_ISAVld & |ChReq, grant first requester at or after ptr (wrapping at NUM_CH-1 -> 0).
//    Latch idx, ChWr, ChAddr, ChLen of the granted channel. Later changes to the inputs are ignored.
//    If latched len==0: ChDone[idx] pulses the next cycle, ptr=idx+1 mod NUM_CH, stay IDLE, no command issued.
//  CMD: O_CmdVld=1, O_DatOE=1, PadDatVldOut=1.
//    PadDatOut = {0.., len[LEN_WIDTH], addr[DRAM_ADDR_WIDTH], dir}; bit0=dir (1=write), addr at [1+:DAW].
//    Leave on PadDatRdyIn: go to WR if dir, else RD. Beat counter cleared.
//  RD: O_DatOE=0. PadDatRdyOut=RdRdy[idx]. RdVld[idx]=PadDatVldIn. RdDat=PadDatIn. All combinational, zero latency.
//  WR: O_DatOE=1, O_CmdVld=0. PadDatOut=ChWrDat[idx]. PadDatVldOut=ChWrVld[idx]. ChWrRdy[idx]=PadDatRdyIn.
//  Beat = valid&ready on the port. Counter is LEN_WIDTH bits. A beat with count==len-1 moves to DONE.
//  DONE: 1 cycle. ChDone[idx]=1, O_DatOE=0, ptr=idx+1 mod NUM_CH, then IDLE.
//  ChGnt[idx]=1 from CMD through DONE inclusive. The new grant may assert the cycle after DONE.
//  I_ISAVld is sampled only in IDLE; no preemption. Host must not assert it outside IDLE.
//  Dropping ChReq while granted has no effect; the transfer completes.
//  Non-granted ChWrRdy/RdVld stay 0. Outside RD, PadDatRdyOut=0. Outside CMD/WR, PadDatVldOut=0.
// TESTING
//  1. Ch1 req wr, addr=0x40, len=3; host rdy=1 -> cmd bit0=1, addr field 0x40; 3 beats; ChDone[1] 1 cycle; OE low in DONE.
//  2. Ch0,Ch2,Ch3 req continuously, len=1 -> grant order 0,2,3,0...; no gap beyond IDLE+CMD+DONE.
//  3. I_ISAVld=1 with ChReq=4'hF -> no ChGnt, no O_CmdVld. Deassert -> grant ch0 next cycle.
//  4. Ch2 len=0 -> ChDone[2] pulse, no O_CmdVld. Ptr advances: next grant goes to ch3 if requesting.
//  5. Rd len=4 with PadDatVldIn/RdRdy toggled randomly -> exactly 4 beats to RdDat in order, then DONE.
//  6. rst_n low mid-WR (beat 2 of 5) -> all outputs 0 async. After release: IDLE, ptr=0, no ChDone.

Source files
------------

// File: rtl/itf_dma_sched.sv
// rtl/itf_dma_sched.sv - round-robin DMA scheduler for the shared off-chip data port
//
// Arbitrates NUM_CH on-chip DMA channels onto one off-chip data port. Each
// transfer is one command beat (len, addr, dir) followed by len data beats,
// DRAM->chip (read) or chip->DRAM (write), then a one-cycle completion pulse.
// The port is left to the host while I_ISAVld is high in IDLE.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   I_ISAVld                      host owns the port (sampled in IDLE only)
//   ChReq/ChWr/ChAddr/ChLen       per-channel request, direction, start address, length
//   ChGnt/ChDone                  one-hot grant (CMD..DONE), one-cycle completion pulse
//   ChWrDat/ChWrVld/ChWrRdy       per-channel write stream (chip->DRAM)
//   RdDat/RdVld/RdRdy             read stream (DRAM->chip), data broadcast
//   O_CmdVld/O_DatOE              command beat marker, chip drives the port
//   PadDatOut/PadDatVldOut        chip-driven port data/valid
//   PadDatRdyIn                   host ready while O_DatOE=1
//   PadDatIn/PadDatVldIn          host-driven port data/valid
//   PadDatRdyOut                  chip ready to host while O_DatOE=0
module itf_dma_sched #(
  parameter int NUM_CH          = 4,
  parameter int PORT_WIDTH      = 128,
  parameter int DRAM_ADDR_WIDTH = 32,
  parameter int LEN_WIDTH       = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                I_ISAVld,
  input  logic [NUM_CH-1:0]                   ChReq,
  input  logic [NUM_CH-1:0]                   ChWr,
  input  logic [NUM_CH*DRAM_ADDR_WIDTH-1:0]   ChAddr,
  input  logic [NUM_CH*LEN_WIDTH-1:0]         ChLen,
  output logic [NUM_CH-1:0]                   ChGnt,
  output logic [NUM_CH-1:0]                   ChDone,
  input  logic [NUM_CH*PORT_WIDTH-1:0]        ChWrDat,
  input  logic [NUM_CH-1:0]                   ChWrVld,
  output logic [NUM_CH-1:0]                   ChWrRdy,
  output logic [PORT_WIDTH-1:0]               RdDat,
  output logic [NUM_CH-1:0]                   RdVld,
  input  logic [NUM_CH-1:0]                   RdRdy,
  output logic                                O_CmdVld,
  output logic                                O_DatOE,
  output logic [PORT_WIDTH-1:0]               PadDatOut,
  output logic                                PadDatVldOut,
  input  logic                                PadDatRdyIn,
  input  logic [PORT_WIDTH-1:0]               PadDatIn,
  input  logic                                PadDatVldIn,
  output logic                                PadDatRdyOut
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_RD   = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           ptr_q;
  logic [IDX_W-1:0]           idx_q;
  logic                       dir_q;
  logic [DRAM_ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]       len_q;
  logic [LEN_WIDTH-1:0]       cnt_q;
  // Completion pulse for zero-length requests; they never leave IDLE.
  logic [NUM_CH-1:0]          zdone_q;

  logic                       arb_hit;
  logic [IDX_W-1:0]           arb_idx;
  logic [IDX_W-1:0]           cand;
  logic                       sel_wr;
  logic [DRAM_ADDR_WIDTH-1:0] sel_addr;
  logic [LEN_WIDTH-1:0]       sel_len;
  logic [PORT_WIDTH-1:0]      gnt_wr_dat;
  logic                       gnt_wr_vld;
  logic                       gnt_rd_rdy;
  logic [NUM_CH-1:0]          idx_oh;
  logic                       grant_go;
  logic                       beat;
  logic                       last_beat;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    if (i == IDX_W'(NUM_CH - 1)) return '0;
    return i + IDX_W'(1);
  endfunction

  // Round-robin: first requester at or after ptr_q, wrapping.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % NUM_CH);
      if (!arb_hit && ChReq[cand]) begin
        arb_hit = 1'b1;
        arb_idx = cand;
      end
    end
  end

  // Transfer descriptor of the channel being arbitrated in.
  always_comb begin
    sel_wr   = 1'b0;
    sel_addr = '0;
    sel_len  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (arb_idx == IDX_W'(k)) begin
        sel_wr   = ChWr[k];
        sel_addr = ChAddr[k*DRAM_ADDR_WIDTH +: DRAM_ADDR_WIDTH];
        sel_len  = ChLen[k*LEN_WIDTH +: LEN_WIDTH];
      end
    end
  end

  // Stream lanes of the channel currently holding the grant.
  always_comb begin
    gnt_wr_dat = '0;
    gnt_wr_vld = 1'b0;
    gnt_rd_rdy = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (idx_q == IDX_W'(k)) begin
        gnt_wr_dat = ChWrDat[k*PORT_WIDTH +: PORT_WIDTH];
        gnt_wr_vld = ChWrVld[k];
        gnt_rd_rdy = RdRdy[k];
      end
    end
  end

  assign idx_oh   = NUM_CH'(1) << idx_q;
  assign grant_go = (state_q == S_IDLE) && !I_ISAVld && arb_hit;

  always_comb begin
    beat = 1'b0;
    case (state_q)
      S_RD:    beat = PadDatVldIn & gnt_rd_rdy;
      S_WR:    beat = gnt_wr_vld & PadDatRdyIn;
      default: beat = 1'b0;
    endcase
  end

  assign last_beat = beat && (cnt_q == (len_q - LEN_WIDTH'(1)));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (grant_go && (sel_len != '0)) state_d = S_CMD;
      S_CMD:  if (PadDatRdyIn) state_d = dir_q ? S_WR : S_RD;
      S_RD,
      S_WR:   if (last_beat) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Latched transfer context, beat counter and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      idx_q   <= '0;
      dir_q   <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      zdone_q <= '0;
    end else begin
      zdone_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (grant_go) begin
            idx_q  <= arb_idx;
            dir_q  <= sel_wr;
            addr_q <= sel_addr;
            len_q  <= sel_len;
            // Empty transfer: complete immediately and move the pointer on.
            if (sel_len == '0) begin
              zdone_q <= NUM_CH'(1) << arb_idx;
              ptr_q   <= next_idx(arb_idx);
            end
          end
        end
        S_CMD: cnt_q <= '0;
        S_RD,
        S_WR:  if (beat) cnt_q <= cnt_q + LEN_WIDTH'(1);
        S_DONE: ptr_q <= next_idx(idx_q);
        default: ;
      endcase
    end
  end

  // Output decode
  always_comb begin
    ChGnt        = '0;
    ChDone       = zdone_q;
    ChWrRdy      = '0;
    RdVld        = '0;
    RdDat        = '0;
    O_CmdVld     = 1'b0;
    O_DatOE      = 1'b0;
    PadDatOut    = '0;
    PadDatVldOut = 1'b0;
    PadDatRdyOut = 1'b0;
    case (state_q)
      S_CMD: begin
        ChGnt        = idx_oh;
        O_CmdVld     = 1'b1;
        O_DatOE      = 1'b1;
        PadDatVldOut = 1'b1;
        PadDatOut    = PORT_WIDTH'({len_q, addr_q, dir_q});
      end
      S_RD: begin
        ChGnt        = idx_oh;
        PadDatRdyOut = gnt_rd_rdy;
        RdVld        = PadDatVldIn ? idx_oh : '0;
        RdDat        = PadDatIn;
      end
      S_WR: begin
        ChGnt        = idx_oh;
        O_DatOE      = 1'b1;
        PadDatOut    = gnt_wr_dat;
        PadDatVldOut = gnt_wr_vld;
        ChWrRdy      = PadDatRdyIn ? idx_oh : '0;
      end
      S_DONE: begin
        ChGnt  = idx_oh;
        ChDone = zdone_q | idx_oh;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_itf_dma_sched.sv
// tb/tb_itf_dma_sched.sv - self-checking bench for itf_dma_sched
`timescale 1ns/1ps
module tb_itf_dma_sched;

  localparam int N  = 4;
  localparam int PW = 128;
  localparam int AW = 32;
  localparam int LW = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            I_ISAVld;
  logic [N-1:0]    ChReq, ChWr, ChGnt, ChDone, ChWrVld, ChWrRdy, RdVld, RdRdy;
  logic [N*AW-1:0] ChAddr;
  logic [N*LW-1:0] ChLen;
  logic [N*PW-1:0] ChWrDat;
  logic [PW-1:0]   RdDat, PadDatOut, PadDatIn;
  logic            O_CmdVld, O_DatOE, PadDatVldOut, PadDatRdyIn, PadDatVldIn, PadDatRdyOut;

  always #5 clk = ~clk;

  itf_dma_sched #(.NUM_CH(N), .PORT_WIDTH(PW), .DRAM_ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .I_ISAVld(I_ISAVld),
    .ChReq(ChReq), .ChWr(ChWr), .ChAddr(ChAddr), .ChLen(ChLen),
    .ChGnt(ChGnt), .ChDone(ChDone),
    .ChWrDat(ChWrDat), .ChWrVld(ChWrVld), .ChWrRdy(ChWrRdy),
    .RdDat(RdDat), .RdVld(RdVld), .RdRdy(RdRdy),
    .O_CmdVld(O_CmdVld), .O_DatOE(O_DatOE),
    .PadDatOut(PadDatOut), .PadDatVldOut(PadDatVldOut), .PadDatRdyIn(PadDatRdyIn),
    .PadDatIn(PadDatIn), .PadDatVldIn(PadDatVldIn), .PadDatRdyOut(PadDatRdyOut)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  int          m_owner;   // channel holding the port, -1 when none
  logic        m_cmd;     // command beat still pending
  logic        m_fin;     // all beats moved, completion cycle
  int          m_left;    // beats still to move
  int          m_ptr;
  logic        m_dir;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_len;
  logic [N-1:0]  m_zdone;
  int          m_pick;
  logic        m_beat;

  function automatic int find_req(input int p, input logic [N-1:0] req);
    for (int k = 0; k < N; k++) if (req[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  always_comb m_pick = find_req(m_ptr, ChReq);

  always_comb begin
    m_beat = 1'b0;
    if (m_owner >= 0 && !m_cmd && !m_fin)
      m_beat = m_dir ? (ChWrVld[m_owner] && PadDatRdyIn) : (PadDatVldIn && RdRdy[m_owner]);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner <= -1; m_cmd <= 1'b0; m_fin <= 1'b0; m_left <= 0; m_ptr <= 0;
      m_dir <= 1'b0; m_addr <= '0; m_len <= '0; m_zdone <= '0;
    end else begin
      m_zdone <= '0;
      if (m_owner < 0) begin
        if (!I_ISAVld && m_pick >= 0) begin
          if (ChLen[m_pick*LW +: LW] == '0) begin
            m_zdone <= N'(1) << m_pick;
            m_ptr   <= (m_pick + 1) % N;
          end else begin
            m_owner <= m_pick;
            m_dir   <= ChWr[m_pick];
            m_addr  <= ChAddr[m_pick*AW +: AW];
            m_len   <= ChLen[m_pick*LW +: LW];
            m_left  <= int'(ChLen[m_pick*LW +: LW]);
            m_cmd   <= 1'b1;
          end
        end
      end else if (m_fin) begin
        m_ptr   <= (m_owner + 1) % N;
        m_owner <= -1;
        m_fin   <= 1'b0;
      end else if (m_cmd) begin
        if (PadDatRdyIn) m_cmd <= 1'b0;
      end else if (m_beat) begin
        m_left <= m_left - 1;
        if (m_left == 1) m_fin <= 1'b1;
      end
    end
  end

  logic [N-1:0]  e_gnt, e_done, e_wrrdy, e_rdvld, e_oh;
  logic [PW-1:0] e_rddat, e_pdo;
  logic          e_cmdv, e_oe, e_pvo, e_pro, e_isc, e_isx;

  always_comb begin
    e_oh    = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    e_isc   = (m_owner >= 0) && m_cmd;
    e_isx   = (m_owner >= 0) && !m_cmd && !m_fin;
    e_gnt   = e_oh;
    e_done  = m_zdone | (m_fin ? e_oh : '0);
    e_cmdv  = e_isc;
    e_oe    = e_isc || (e_isx && m_dir);
    e_pdo   = '0;
    e_pvo   = e_isc;
    e_wrrdy = '0;
    e_rdvld = '0;
    e_rddat = '0;
    e_pro   = 1'b0;
    if (e_isc) e_pdo = PW'({m_len, m_addr, m_dir});
    if (e_isx && m_dir) begin
      e_pdo   = ChWrDat[m_owner*PW +: PW];
      e_pvo   = ChWrVld[m_owner];
      e_wrrdy = PadDatRdyIn ? e_oh : '0;
    end
    if (e_isx && !m_dir) begin
      e_rdvld = PadDatVldIn ? e_oh : '0;
      e_rddat = PadDatIn;
      e_pro   = RdRdy[m_owner];
    end
  end

  always @(negedge clk) begin
    check("ChGnt", 256'(ChGnt), 256'(e_gnt));
    check("ChDone", 256'(ChDone), 256'(e_done));
    check("ChWrRdy", 256'(ChWrRdy), 256'(e_wrrdy));
    check("RdVld", 256'(RdVld), 256'(e_rdvld));
    check("RdDat", 256'(RdDat), 256'(e_rddat));
    check("O_CmdVld", 256'(O_CmdVld), 256'(e_cmdv));
    check("O_DatOE", 256'(O_DatOE), 256'(e_oe));
    check("PadDatOut", 256'(PadDatOut), 256'(e_pdo));
    check("PadDatVldOut", 256'(PadDatVldOut), 256'(e_pvo));
    check("PadDatRdyOut", 256'(PadDatRdyOut), 256'(e_pro));
  end

  // ---------------- monitor (records events for literal checks) ----------------
  int            cyc = 0;
  int            g_idx[$];
  int            g_cyc[$];
  logic [PW-1:0] cmd_words[$];
  logic [PW-1:0] rd_beats[$];
  int            done_cnt[N];
  int            cmd_cycles = 0;
  int            busy_cycles = 0;
  int            wr_beats = 0;
  logic [N-1:0]  prev_gnt = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    prev_gnt <= ChGnt;
    if (ChGnt != '0 && ChGnt != prev_gnt) begin
      for (int k = 0; k < N; k++) if (ChGnt[k]) g_idx.push_back(k);
      g_cyc.push_back(cyc);
    end
    for (int k = 0; k < N; k++) if (ChDone[k]) done_cnt[k] <= done_cnt[k] + 1;
    if (O_CmdVld) begin
      cmd_cycles <= cmd_cycles + 1;
      cmd_words.push_back(PadDatOut);
    end
    if (ChGnt != '0 || O_CmdVld) busy_cycles <= busy_cycles + 1;
    if (|(ChWrRdy & ChWrVld)) wr_beats <= wr_beats + 1;
    if (|(RdVld & RdRdy)) rd_beats.push_back(RdDat);
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ChReq = '0; I_ISAVld = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic set_ch(input int c, input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] l);
    ChWr[c] = wr;
    ChAddr[c*AW +: AW] = a;
    ChLen[c*LW +: LW] = l;
  endtask

  task automatic wait_done(input int c, input int base, input int budget, input string name);
    int t = 0;
    while (done_cnt[c] <= base && t < budget) begin step(1); t++; end
    if (done_cnt[c] <= base) check({name, "_timeout"}, 256'(done_cnt[c]), 256'(base + 1));
  endtask

  task automatic wait_gnt(input int c, input int budget, input string name);
    int t = 0;
    while (!ChGnt[c] && t < budget) begin step(1); t++; end
    if (!ChGnt[c]) check({name, "_timeout"}, 256'(ChGnt), 256'(N'(1) << c));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    int bc, bw, bd, bg, br, t;
    I_ISAVld = 0; ChReq = '0; ChWr = '0; ChAddr = '0; ChLen = '0; ChWrDat = '0;
    ChWrVld = '0; RdRdy = '0; PadDatRdyIn = 0; PadDatIn = '0; PadDatVldIn = 0;
    #2 rst_n = 1'b0;
    #1;
    check("reset_ctrl", 256'({ChGnt, ChDone, ChWrRdy, RdVld, O_CmdVld, O_DatOE, PadDatVldOut, PadDatRdyOut}), 256'(0));
    check("reset_data", {RdDat, PadDatOut}, 256'(0));
    step(2);
    rst_n = 1'b1;

    // 1: channel 1 write, addr 0x40, len 3
    set_ch(1, 1'b1, 32'h40, 16'd3);
    ChWrDat[PW +: PW] = 128'hBEEF; ChWrVld = 4'b0010; PadDatRdyIn = 1'b1;
    bc = cmd_words.size(); bw = wr_beats; bd = done_cnt[1]; bg = g_idx.size();
    ChReq = 4'b0010;
    wait_gnt(1, 10, "t1_gnt");
    ChReq = '0;
    wait_done(1, bd, 20, "t1_done");
    step(3);
    check("t1_cmd_word", (cmd_words.size() > bc) ? 256'(cmd_words[bc]) : 256'(0), 256'(128'h6_0000_0081));
    check("t1_wr_beats", 256'(wr_beats - bw), 256'(3));
    check("t1_done_pulses", 256'(done_cnt[1] - bd), 256'(1));
    check("t1_grants", 256'(g_idx.size() - bg), 256'(1));

    // 2: ch0, ch2, ch3 reads of len 1 requested continuously
    do_reset();
    set_ch(0, 1'b0, 32'h10, 16'd1); set_ch(2, 1'b0, 32'h20, 16'd1); set_ch(3, 1'b0, 32'h30, 16'd1);
    RdRdy = 4'hF; PadDatVldIn = 1'b1; PadDatIn = 128'h5A;
    bg = g_idx.size();
    ChReq = 4'b1101;
    step(20);
    ChReq = '0;
    step(6);
    check("t2_g0", (g_idx.size() > bg + 0) ? 256'(g_idx[bg + 0]) : 256'hFF, 256'(0));
    check("t2_g1", (g_idx.size() > bg + 1) ? 256'(g_idx[bg + 1]) : 256'hFF, 256'(2));
    check("t2_g2", (g_idx.size() > bg + 2) ? 256'(g_idx[bg + 2]) : 256'hFF, 256'(3));
    check("t2_g3", (g_idx.size() > bg + 3) ? 256'(g_idx[bg + 3]) : 256'hFF, 256'(0));
    for (int i = 0; i < 3; i++)
      check("t2_gap", (g_cyc.size() > bg + i + 1) ? 256'(g_cyc[bg + i + 1] - g_cyc[bg + i]) : 256'(0), 256'(4));

    // 3: host streaming blocks the port
    do_reset();
    for (int c = 0; c < N; c++) set_ch(c, 1'b0, 32'h100 + AW'(c), 16'd2);
    I_ISAVld = 1'b1;
    bc = busy_cycles;
    ChReq = 4'hF;
    step(6);
    check("t3_blocked", 256'(busy_cycles - bc), 256'(0));
    I_ISAVld = 1'b0;
    bd = done_cnt[0];
    step(1);
    check("t3_gnt_ch0", 256'(ChGnt), 256'(4'b0001));
    ChReq = '0;
    wait_done(0, bd, 20, "t3_done");
    step(2);

    // 4: zero-length on ch2, then ch3 gets the next grant
    do_reset();
    set_ch(2, 1'b0, 32'h80, 16'd0); set_ch(3, 1'b0, 32'h90, 16'd1);
    bc = cmd_cycles; bd = done_cnt[2]; bg = g_idx.size();
    ChReq = 4'b1100;
    wait_done(2, bd, 10, "t4_zdone");
    check("t4_no_cmd", 256'(cmd_cycles - bc), 256'(0));
    wait_gnt(3, 10, "t4_gnt3");
    ChReq = '0;
    bw = done_cnt[3];
    wait_done(3, bw, 20, "t4_done3");
    step(2);
    check("t4_next_grant", (g_idx.size() > bg) ? 256'(g_idx[bg]) : 256'hFF, 256'(3));
    check("t4_zdone_once", 256'(done_cnt[2] - bd), 256'(1));

    // 5: read len 4 with random host valid / chip ready
    do_reset();
    set_ch(0, 1'b0, 32'h100, 16'd4);
    br = rd_beats.size(); bd = done_cnt[0];
    PadDatIn = 128'hA000; PadDatVldIn = 1'b0; RdRdy = '0;
    ChReq = 4'b0001;
    t = 0;
    while (done_cnt[0] <= bd && t < 200) begin
      step(1); t++;
      if (ChGnt[0]) ChReq = '0;
      PadDatIn    = 128'hA000 + PW'(rd_beats.size() - br);
      PadDatVldIn = 1'($urandom_range(0, 1));
      RdRdy[0]    = 1'($urandom_range(0, 1));
    end
    if (done_cnt[0] <= bd) check("t5_timeout", 256'(done_cnt[0]), 256'(bd + 1));
    step(2);
    check("t5_beats", 256'(rd_beats.size() - br), 256'(4));
    for (int i = 0; i < 4; i++)
      check("t5_data", (rd_beats.size() > br + i) ? 256'(rd_beats[br + i]) : 256'(0), 256'(128'hA000 + i));

    // 6: asynchronous reset in the middle of a 5-beat write
    do_reset();
    set_ch(1, 1'b1, 32'h200, 16'd5);
    ChWrDat[PW +: PW] = 128'h77; ChWrVld = 4'b0010; PadDatRdyIn = 1'b1;
    PadDatVldIn = 1'b0; RdRdy = '0;
    bw = wr_beats; bd = done_cnt[1];
    ChReq = 4'b0010;
    t = 0;
    while (wr_beats - bw < 2 && t < 20) begin step(1); t++; end
    check("t6_mid_beats", 256'(wr_beats - bw), 256'(2));
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_ctrl", 256'({ChGnt, ChDone, ChWrRdy, RdVld, O_CmdVld, O_DatOE, PadDatVldOut, PadDatRdyOut}), 256'(0));
    check("t6_rst_data", {RdDat, PadDatOut}, 256'(0));
    ChReq = '0;
    step(2);
    rst_n = 1'b1;
    step(4);
    check("t6_no_done", 256'(done_cnt[1] - bd), 256'(0));
    set_ch(0, 1'b0, 32'h10, 16'd1); set_ch(3, 1'b0, 32'h30, 16'd1);
    RdRdy = 4'hF; PadDatVldIn = 1'b1;
    bg = g_idx.size(); bd = done_cnt[0];
    ChReq = 4'b1001;
    step(2);
    ChReq = '0;
    wait_done(0, bd, 20, "t6_done0");
    step(3);
    check("t6_ptr_reset", (g_idx.size() > bg) ? 256'(g_idx[bg]) : 256'hFF, 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
